event_readout_scheduler: RTL and testbench

Buffers encoded address events from the pixel-hierarchy event encoder in a first-word-fall-through (FWFT) FIFO and schedules their readout onto a valid/ready output link. Readout is organised as bursts, terminated by a final-beat marker. When the FIFO nears full, the block stalls arbitration upstream with a hysteresis hold. Events that arrive when no slot is free are dropped and counted. It sits between the hierarchy's event output and the chip's off-array event interface.

---
 rtl/event_readout_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_event_readout_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_readout_scheduler.sv
// ---------------------------------------------------------------------------
// event_readout_scheduler
//
// Buffers encoded address events in a first-word-fall-through FIFO and hands
// them to a valid/ready link as bursts. A burst is BURST beats. A flush
// drains a partial FIFO and is started by a group release, or by an idle
// timeout when that option is built in. Each burst or flush ends with a
// last-beat marker. When the FIFO nears full, arb_hold_o asks the pixel
// hierarchy to stall, with hysteresis. Events that find no free slot are
// dropped and counted.
//
// Build option:
//   EVT_TIMEOUT_FLUSH_EN  - when defined, an 8-bit idle timer flushes a
//                           partial burst after TIMEOUT idle cycles. When
//                           undefined, only a group release flushes.
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous, active-high reset
//   evt_valid_i    event word present this cycle
//   evt_data_i     encoded event word
//   grp_release_i  group release; a rising edge requests a flush
//   arb_hold_o     stall request to the pixel hierarchy
//   out_valid_o    output beat valid
//   out_data_o     output event word (FIFO head), zero when not valid
//   out_last_o     final beat of a burst or flush
//   out_ready_i    downstream accepts the beat
//   fifo_count_o   current FIFO occupancy
//   drop_count_o   dropped events, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module event_readout_scheduler #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int BURST    = 4,
    parameter int AFULL_TH = 12,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       evt_valid_i,
    input  logic [DATA_W-1:0]          evt_data_i,
    input  logic                       grp_release_i,
    output logic                       arb_hold_o,
    output logic                       out_valid_o,
    output logic [DATA_W-1:0]          out_data_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic [15:0]                drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_BURST    = CW'(BURST);
    localparam logic [CW-1:0] C_AFULL_HI = CW'(AFULL_TH);
    localparam logic [CW-1:0] C_AFULL_LO = CW'(AFULL_TH - 4);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_drop_count;
    logic              r_arb_hold;
    logic              r_release_d;
    logic              r_release_pend;
    state_t            r_state;
    logic [CW-1:0]     r_beat;
    logic [CW-1:0]     r_flush_n;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CW-1:0]     w_count_next;
    logic [CW-1:0]     w_last_idx;
    logic              w_timeout;
    logic              w_start_burst;
    logic              w_start_flush;

    // A slot freed by a pop in this cycle can be reused by a push in the
    // same cycle, so a full FIFO still accepts when it is being read.
    assign w_pop  = (r_state != S_IDLE) && out_ready_i;
    assign w_push = evt_valid_i && ((r_count != C_DEPTH) || w_pop);
    assign w_drop = evt_valid_i && !w_push;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_next = r_count - 1'b1;
    end

    assign w_start_burst = (r_state == S_IDLE) && (r_count >= C_BURST);
    assign w_start_flush = (r_state == S_IDLE) && !w_start_burst &&
                           (r_count != '0) && (r_release_pend || w_timeout);

    // FIFO storage. It has no reset: a reset clears the pointers and the
    // count, which discards the contents.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= evt_data_i;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            if (w_drop && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 1'b1;
        end
    end

    // The hold flag is computed from the next occupancy, so it changes in
    // the same cycle that fifo_count_o crosses a threshold.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_arb_hold <= 1'b0;
        else if (w_count_next >= C_AFULL_HI)
            r_arb_hold <= 1'b1;
        else if (w_count_next <= C_AFULL_LO)
            r_arb_hold <= 1'b0;
    end

    // A new release edge wins over the clear, so a release that arrives
    // as a flush starts is not lost.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_release_d    <= 1'b0;
            r_release_pend <= 1'b0;
        end else begin
            r_release_d <= grp_release_i;
            if (grp_release_i && !r_release_d)
                r_release_pend <= 1'b1;
            else if (w_start_flush)
                r_release_pend <= 1'b0;
        end
    end

`ifdef EVT_TIMEOUT_FLUSH_EN
    logic [7:0] r_timer;

    assign w_timeout = (r_timer == 8'(TIMEOUT));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_timer <= '0;
        else if ((r_state != S_IDLE) || (r_count == '0) || w_start_burst || w_start_flush)
            r_timer <= '0;
        else if (!w_timeout)
            r_timer <= r_timer + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_flush_n <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_burst) begin
                        r_state <= S_BURST;
                        r_beat  <= '0;
                    end else if (w_start_flush) begin
                        r_state   <= S_FLUSH;
                        r_flush_n <= r_count;
                        r_beat    <= '0;
                    end
                end
                S_BURST, S_FLUSH: begin
                    if (out_ready_i) begin
                        r_beat <= r_beat + 1'b1;
                        if (out_last_o)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flush ends after the count latched at its start. Events pushed
    // during the flush stay for the next schedule decision.
    assign w_last_idx = (r_state == S_FLUSH) ? (r_flush_n - 1'b1) : (C_BURST - 1'b1);

    // The head pointer only moves on a handshake, so data and last hold
    // steady while the beat is stalled.
    assign out_valid_o  = (r_state != S_IDLE);
    assign out_last_o   = out_valid_o && (r_beat == w_last_idx);
    assign out_data_o   = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign arb_hold_o   = r_arb_hold;
    assign fifo_count_o = r_count;
    assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_event_readout_scheduler.sv
module tb_event_readout_scheduler;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        evt_valid_i;
    logic [31:0] evt_data_i;
    logic        grp_release_i;
    logic        arb_hold_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic [4:0]  fifo_count_o;
    logic [15:0] drop_count_o;

    logic [31:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          waited;
    int          seen;

    always #5 clk_i = ~clk_i;

    event_readout_scheduler #(
        .DATA_W(32), .DEPTH(16), .BURST(4), .AFULL_TH(12), .TIMEOUT(255)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .evt_valid_i(evt_valid_i),
        .evt_data_i(evt_data_i),
        .grp_release_i(grp_release_i),
        .arb_hold_o(arb_hold_o),
        .out_valid_o(out_valid_o),
        .out_data_o(out_data_o),
        .out_last_o(out_last_o),
        .out_ready_i(out_ready_i),
        .fifo_count_o(fifo_count_o),
        .drop_count_o(drop_count_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One push per call; the caller records accepted words in exp_q.
    task automatic push(input logic [31:0] d);
        evt_valid_i = 1'b1;
        evt_data_i  = d;
        tick();
        evt_valid_i = 1'b0;
        $display("[TB] push %08h count=%0d drops=%0d", d, fifo_count_o, drop_count_o);
    endtask

    task automatic pulse_release();
        grp_release_i = 1'b1;
        tick();
        grp_release_i = 1'b0;
    endtask

    // Receives n beats; the n-th must carry out_last_o. Idle samples before
    // the first beat are returned in w. In random mode the first valid beat
    // is always stalled once so the hold behaviour is exercised.
    task automatic recv(input int n, input bit rnd, input int bound, output int w);
        int          got   = 0;
        int          cyc   = 0;
        bit          first = 1'b1;
        bit          stalled = 1'b0;
        logic [31:0] sd = '0;
        logic        sl = 1'b0;
        logic [31:0] e;
        w = 0;
        while (got < n) begin
            if (cyc >= bound) begin
                check_eq("recv_timeout", 32'(got), 32'(n));
                return;
            end
            if (out_valid_o) begin
                if (stalled) begin
                    check_eq("stall_data", out_data_o, sd);
                    check_eq("stall_last", 32'(out_last_o), 32'(sl));
                end
                if (rnd) begin
                    out_ready_i = first ? 1'b0 : 1'($urandom_range(0, 1));
                    first = 1'b0;
                end
                if (out_ready_i) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    check_eq("beat_data", out_data_o, e);
                    check_eq("beat_last", 32'(out_last_o), 32'(got == n - 1));
                    $display("[TB] beat %0d/%0d data=%08h last=%0b", got + 1, n, out_data_o, out_last_o);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = out_data_o;
                    sl = out_last_o;
                end
            end else begin
                if (got > 0 || stalled)
                    check_eq("burst_gap", 32'(out_valid_o), 32'd1);
                if (got == 0)
                    w++;
            end
            tick();
            cyc++;
        end
        out_ready_i = 1'b1;
    endtask

    initial begin
        reset_i       = 1'b1;
        evt_valid_i   = 1'b0;
        evt_data_i    = '0;
        grp_release_i = 1'b0;
        out_ready_i   = 1'b0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_last",  32'(out_last_o),  32'd0);
        check_eq("rst_hold",  32'(arb_hold_o),  32'd0);
        check_eq("rst_count", 32'(fifo_count_o), 32'd0);
        check_eq("rst_drops", 32'(drop_count_o), 32'd0);
        check_eq("rst_data",  out_data_o, 32'd0);
        reset_i = 1'b0;
        tick();

        // Full burst of 4, continuous ready
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'hD000_0000 + 32'(i));
            exp_q.push_back(32'hD000_0000 + 32'(i));
        end
        check_eq("t1_count4", 32'(fifo_count_o), 32'd4);
        check_eq("t1_valid_not_yet", 32'(out_valid_o), 32'd0);
        recv(4, 1'b0, 50, waited);
        check_eq("t1_latency", 32'(waited), 32'd1);
        check_eq("t1_count0", 32'(fifo_count_o), 32'd0);
        check_eq("t1_idle", 32'(out_valid_o), 32'd0);

        // Group release flushes a partial burst of 2
        push(32'hE000_0000);
        push(32'hE000_0001);
        exp_q.push_back(32'hE000_0000);
        exp_q.push_back(32'hE000_0001);
        repeat (3) tick();
        check_eq("t2_no_early", 32'(out_valid_o), 32'd0);
        pulse_release();
        recv(2, 1'b0, 20, waited);
        check_eq("t2_latency", 32'(waited), 32'd1);
        check_eq("t2_count0", 32'(fifo_count_o), 32'd0);

        // A single event must not be flushed by a stale release request
        push(32'hA000_0001);
        exp_q.push_back(32'hA000_0001);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o) seen++;
            tick();
        end
        check_eq("t2_pend_cleared", 32'(seen), 32'd0);

`ifdef EVT_TIMEOUT_FLUSH_EN
        // Timer flush: 256 idle samples after the push, 20 already spent
        recv(1, 1'b0, 400, waited);
        check_eq("t3_timeout_wait", 32'(waited), 32'd236);
`else
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (out_valid_o) seen++;
            tick();
        end
        check_eq("t3_no_timeout_flush", 32'(seen), 32'd0);
        pulse_release();
        recv(1, 1'b0, 20, waited);
`endif
        check_eq("t3_count0", 32'(fifo_count_o), 32'd0);

        // Overflow: 20 pushes, ready low; 16 kept, 4 dropped
        out_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(32'hF000_0000 + 32'(i));
            if (i < 16) exp_q.push_back(32'hF000_0000 + 32'(i));
            if (i == 10) check_eq("t4_hold_at11", 32'(arb_hold_o), 32'd0);
            if (i == 11) check_eq("t4_hold_at12", 32'(arb_hold_o), 32'd1);
        end
        check_eq("t4_count16", 32'(fifo_count_o), 32'd16);
        check_eq("t4_drops4", 32'(drop_count_o), 32'd4);
        check_eq("t4_hold", 32'(arb_hold_o), 32'd1);
        check_eq("t4_head", out_data_o, 32'hF000_0000);

        // Push and pop together while full: both succeed, count stays 16
        out_ready_i = 1'b1;
        evt_valid_i = 1'b1;
        evt_data_i  = 32'hB000_0016;
        void'(exp_q.pop_front());
        exp_q.push_back(32'hB000_0016);
        tick();
        evt_valid_i = 1'b0;
        check_eq("t4_full_pushpop_count", 32'(fifo_count_o), 32'd16);
        check_eq("t4_full_pushpop_drops", 32'(drop_count_o), 32'd4);
        recv(3, 1'b0, 20, waited);
        check_eq("t4_count13", 32'(fifo_count_o), 32'd13);
        check_eq("t4_hold13", 32'(arb_hold_o), 32'd1);
        recv(4, 1'b0, 20, waited);
        check_eq("t4_count9", 32'(fifo_count_o), 32'd9);
        check_eq("t4_hold9", 32'(arb_hold_o), 32'd1);
        recv(4, 1'b0, 20, waited);
        check_eq("t4_count5", 32'(fifo_count_o), 32'd5);
        check_eq("t4_hold5", 32'(arb_hold_o), 32'd0);
        recv(4, 1'b0, 20, waited);
        check_eq("t4_count1", 32'(fifo_count_o), 32'd1);
        pulse_release();
        recv(1, 1'b0, 20, waited);
        check_eq("t4_count0", 32'(fifo_count_o), 32'd0);

        // Random backpressure during a burst
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'hC000_0000 + 32'(i));
            exp_q.push_back(32'hC000_0000 + 32'(i));
        end
        recv(4, 1'b1, 200, waited);
        check_eq("t5_count0", 32'(fifo_count_o), 32'd0);

        // Asynchronous reset in the middle of a burst
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h9000_0000 + 32'(i));
        tick();
        check_eq("t6_pre_valid", 32'(out_valid_o), 32'd1);
        check_eq("t6_pre_data", out_data_o, 32'h9000_0000);
        #3;
        reset_i = 1'b1;
        #1;
        check_eq("t6_async_valid", 32'(out_valid_o), 32'd0);
        check_eq("t6_async_count", 32'(fifo_count_o), 32'd0);
        check_eq("t6_async_data", out_data_o, 32'd0);
        check_eq("t6_async_drops", 32'(drop_count_o), 32'd0);
        tick();
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid_o) seen++;
            tick();
        end
        check_eq("t6_no_stale", 32'(seen), 32'd0);
        for (int i = 0; i < 4; i++) begin
            push(32'h8000_0000 + 32'(i));
            exp_q.push_back(32'h8000_0000 + 32'(i));
        end
        recv(4, 1'b0, 50, waited);
        check_eq("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
